// File: rtl/count_seq_ctrl.sv
// Programmable interval timer around a WIDTH-bit counter: one-shot / auto-reload, pause, stop.
// Optional tick prescaler enabled by defining COUNT_SEQ_CTRL_PRESCALE_EN.
module count_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             reload,
  input  logic [WIDTH-1:0] period,
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic [PRE_W-1:0] pre_src;
  logic             busy_q, tc_q, done_q;
  logic             tc_d;
  logic             advance;
  logic             tick;

  // Without the prescaler the divider is held at zero, so every advancing cycle ticks.
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
  assign pre_src = prescale;
`else
  assign pre_src = '0;
`endif

  assign tick = (pcnt_q == pre_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    per_d   = per_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    advance = 1'b0;

    if (stop) begin
      state_d = StIdle;
      count_d = '0;
      pcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            per_d   = period;
            mode_d  = reload;
            pre_d   = pre_src;
            count_d = '0;
            pcnt_d  = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (pause) state_d = StHold;
          else       advance = 1'b1;
        end
        StHold: begin
          // Leaving HOLD advances immediately so each HOLD cycle costs exactly one tick slot.
          if (!pause) begin
            state_d = StRun;
            advance = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (advance) begin
      if (tick) begin
        pcnt_d = '0;
        if (count_q != per_q) begin
          count_d = count_q + 1'b1;
        end else begin
          tc_d = 1'b1;
          if (mode_q) count_d = '0;
          else        state_d = StDone;
        end
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= (state_d == StRun) || (state_d == StHold);
      tc_q    <= tc_d;
      done_q  <= (state_d == StDone);
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl (default build, no prescaler).
module tb_count_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       reload;
  logic [3:0] period;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  count_seq_ctrl #(
    .WIDTH(4),
    .PRE_W(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .reload(reload),
    .period(period),
    .count (count),
    .busy  (busy),
    .tc    (tc),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input int c, input int b, input int t, input int d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".tc"},    32'(tc),    32'(t));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_all("stop", 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; reload = 1'b0; period = 4'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check_all("reset", 0, 0, 0, 0);

    // Auto-reload, period 3: tc every 4 cycles.
    period = 4'd3; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check_all("rl3_start", 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check_all($sformatf("rl3_%0d", i), i % 4, 1, (i % 4 == 0) ? 1 : 0, 0);
    end
    do_stop();

    // One-shot, period 5.
    period = 4'd5; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    period = 4'd1;  // must not affect the running interval
    check_all("os5_start", 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_all($sformatf("os5_%0d", i), i, 1, 0, 0);
    end
    step();
    check_all("os5_term", 5, 0, 1, 1);
    step();
    check_all("os5_hold1", 5, 0, 0, 1);
    step();
    check_all("os5_hold2", 5, 0, 0, 1);
    // Back-to-back restart from DONE with the new period 1.
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("b2b_start", 0, 1, 0, 0);
    step();
    check_all("b2b_1", 1, 1, 0, 0);
    step();
    check_all("b2b_term", 1, 0, 1, 1);
    do_stop();

    // Pause for two cycles at count 1 delays tc by two cycles.
    period = 4'd3; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check_all("ps_start", 0, 1, 0, 0);
    step();
    check_all("ps_1", 1, 1, 0, 0);
    pause = 1'b1;
    step();
    check_all("ps_hold1", 1, 1, 0, 0);
    step();
    check_all("ps_hold2", 1, 1, 0, 0);
    pause = 1'b0;
    step();
    check_all("ps_2", 2, 1, 0, 0);
    step();
    check_all("ps_3", 3, 1, 0, 0);
    step();
    check_all("ps_tc", 0, 1, 1, 0);
    do_stop();

    // stop together with start on the terminal edge suppresses tc.
    period = 4'd2; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_all("st_at2", 2, 1, 0, 0);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check_all("st_term", 0, 0, 0, 0);
    step();
    check_all("st_idle", 0, 0, 0, 0);

    // Period 0, reload: tc every cycle; start during RUN ignored.
    period = 4'd0; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check_all("p0_start", 0, 1, 0, 0);
    step();
    check_all("p0_1", 0, 1, 1, 0);
    step();
    check_all("p0_2", 0, 1, 1, 0);
    period = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    check_all("p0_ign", 0, 1, 1, 0);
    step();
    check_all("p0_3", 0, 1, 1, 0);
    do_stop();

    // Period 0, one-shot: DONE after one tick.
    period = 4'd0; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_all("p0os_start", 0, 1, 0, 0);
    step();
    check_all("p0os_term", 0, 0, 1, 1);
    do_stop();

    // Full-range period wraps through every value.
    period = 4'd15; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("wrap_%0d.count", i), 32'(count), 32'(i % 16));
      check($sformatf("wrap_%0d.tc", i), 32'(tc), (i == 16) ? 32'd1 : 32'd0);
    end
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Sequencing controller for the team's 4-bit counters. It turns a free-running count into a programmable interval timer with start, stop and pause control. It supports one-shot and auto-reload modes, a single-cycle terminal-count pulse and busy/done status. It sits between control logic and any block that needs a periodic or single timed event.

## Interface
Parameters:
- WIDTH, 4, counter and period width
- PRE_W, 4, prescaler width (used only when COUNT_SEQ_CTRL_PRESCALE_EN is defined)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; launches a run from IDLE or DONE
- stop  input  1  pulse; aborts any state to IDLE
- pause  input  1  level; freezes counting while high in RUN
- reload  input  1  mode, latched at start: 1 = auto-reload, 0 = one-shot
- period  input  WIDTH  terminal value N; run counts 0..N, latched at start
- prescale  input  PRE_W  tick divider P, latched at start (only with macro)
- count  output  WIDTH  current count value
- busy  output  1  high in RUN and HOLD
- tc  output  1  one-cycle terminal-count pulse
- done  output  1  high in DONE (one-shot finished)

## Operation
- The state machine has four states: IDLE, RUN, HOLD and DONE. All outputs are registered.
- Reset (rst high at an edge):
  - State goes to IDLE.
  - count=0, busy=0, tc=0, done=0.
  - Latched period, mode and prescale clear to 0.
- IDLE: count=0. When start is high, the block latches period→per_r and reload→mode_r, sets count=0 and enters RUN.
- DONE: count holds per_r and done=1. When start is high, the block relatches and enters RUN with count=0 and done=0.
- RUN, on each tick (every cycle without the macro):
  - count≠per_r: count+1.
  - count==per_r, mode_r=1: count←0, tc←1, stay in RUN.
  - count==per_r, mode_r=0: count holds, tc←1, done←1, go to DONE.
- pause high in RUN:
  - Go to HOLD; no tick is consumed that cycle.
  - In HOLD, count and the prescaler are frozen.
  - When pause goes low, return to RUN; counting resumes the next cycle.
- stop has priority over start, pause and tick (below rst only):
  - Any state goes to IDLE with count=0, busy=0 and done=0.
  - No tc is issued, even if the terminal was reached that same cycle.
- start while in RUN or HOLD is ignored. Changes to period/reload after start have no effect until the next start.
- per_r=0: every tick is terminal.
  - Reload mode: tc on every tick and count stays 0.
  - One-shot mode: DONE after one tick.
- Arithmetic is unsigned and modulo 2^WIDTH. With per_r=2^WIDTH−1, the count passes through all values before wrapping to 0.

## Timing
- start sampled high at edge k:
  - After edge k: busy=1, count=0.
  - After edge k+i (i ≤ N): count=i.
- Terminal at edge k+N+1:
  - tc=1 for exactly one cycle.
  - Reload mode: count=0.
  - One-shot mode: count=N, done=1, busy=0.
- In reload mode, tc repeats every N+1 cycles. Each cycle spent in HOLD extends the interval by one.
- stop sampled high at an edge: IDLE outputs are visible immediately after that edge.
- Back-to-back: start in the first DONE cycle gives count=0, busy=1 after that edge.

## Configuration
- COUNT_SEQ_CTRL_PRESCALE_EN defined:
  - Adds the prescale port and a PRE_W prescaler, latched as pre_r at start and cleared at start.
  - A tick occurs every pre_r+1 cycles in RUN, so the tc interval is (N+1)(P+1) cycles.
  - The prescaler is frozen in HOLD and cleared by stop or rst.
- Macro undefined: no prescale port; a tick occurs every RUN cycle.

## Test plan
- Reset, then period=3, reload=1, start at cycle 0: count 0,1,2,3,0,1…; tc high at cycles 4, 8, 12; busy=1; done=0.
- period=5, reload=0, start: count reaches 5; at the next edge tc=1 for one cycle, done=1, busy=0; count stays 5 until start.
- period=3, reload=1, pause high for 2 cycles at count=1: count stays 1 for 2 extra cycles; next tc is 2 cycles later than nominal.
- stop asserted at the same edge that count==period, alongside start: tc stays 0; state IDLE; count=0; done=0.
- period=0, reload=1: tc high every cycle and count=0. Then start during RUN with period=7: ignored; interval unchanged.
- With COUNT_SEQ_CTRL_PRESCALE_EN, prescale=2, period=1, reload=1: count changes every 3 cycles; tc every 6 cycles.
